// File: rtl/mpu_reg_write_arbiter_if.sv
// Purpose: bundle of requester-side and register-file-side signals for the
//          matrix register-file write arbiter.
// Ports (signals):
//   requester side : req_in, wr_en_in, addr_in, element_in, i_loc_in, j_loc_in,
//                    m_size_in, n_size_in (packed per requester), grant_out
//   register file  : reg_ready_in, reg_en_out, reg_addr_out, reg_element_out,
//                    reg_i_loc_out, reg_j_loc_out, reg_m_size_out, reg_n_size_out
//   status         : busy_out, abort_out, collide_out
// Modports: master = environment (requesters + register file), slave = arbiter.
interface mpu_reg_write_arbiter_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned MW     = 3,
  parameter int unsigned NW     = 3
);
  logic [NREQ-1:0]        req_in;
  logic [NREQ-1:0]        wr_en_in;
  logic [NREQ*ADDR_W-1:0] addr_in;
  logic [NREQ*32-1:0]     element_in;
  logic [NREQ*MW-1:0]     i_loc_in;
  logic [NREQ*NW-1:0]     j_loc_in;
  logic [NREQ*MW-1:0]     m_size_in;
  logic [NREQ*NW-1:0]     n_size_in;
  logic                   reg_ready_in;

  logic [NREQ-1:0]        grant_out;
  logic                   reg_en_out;
  logic [ADDR_W-1:0]      reg_addr_out;
  logic [31:0]            reg_element_out;
  logic [MW-1:0]          reg_i_loc_out;
  logic [NW-1:0]          reg_j_loc_out;
  logic [MW-1:0]          reg_m_size_out;
  logic [NW-1:0]          reg_n_size_out;
  logic                   busy_out;
  logic                   abort_out;
  logic                   collide_out;

  modport master (
    output req_in, wr_en_in, addr_in, element_in, i_loc_in, j_loc_in,
           m_size_in, n_size_in, reg_ready_in,
    input  grant_out, reg_en_out, reg_addr_out, reg_element_out,
           reg_i_loc_out, reg_j_loc_out, reg_m_size_out, reg_n_size_out,
           busy_out, abort_out, collide_out
  );

  modport slave (
    input  req_in, wr_en_in, addr_in, element_in, i_loc_in, j_loc_in,
           m_size_in, n_size_in, reg_ready_in,
    output grant_out, reg_en_out, reg_addr_out, reg_element_out,
           reg_i_loc_out, reg_j_loc_out, reg_m_size_out, reg_n_size_out,
           busy_out, abort_out, collide_out
  );
endinterface

// File: rtl/mpu_reg_write_arbiter.sv
// Purpose: shares the single matrix register-file write port between NREQ
//          requesters. Round-robin arbitration; the grant stays locked to one
//          requester for a whole matrix transfer (first through last element).
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active high
//   bus  : mpu_reg_write_arbiter_if.slave (requester fields in, grant and
//          muxed register-file write fields out, busy/abort/collide status)
module mpu_reg_write_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned MW     = 3,
  parameter int unsigned NW     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  mpu_reg_write_arbiter_if.slave      bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_XFER  = 2'd2
  } arb_state_e;

  arb_state_e       state_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    winner_q;
  logic [NREQ-1:0]  grant_q;
  logic             abort_q;
  logic             collide_q;

  // Winner's fields, selected by the locked winner index
  logic             wr_w;
  logic             req_w;
  logic [ADDR_W-1:0] addr_w;
  logic [31:0]      element_w;
  logic [MW-1:0]    i_w;
  logic [NW-1:0]    j_w;
  logic [MW-1:0]    m_w;
  logic [NW-1:0]    n_w;
  logic             grant_act;
  logic             last_c;
  logic [PW-1:0]    ptr_next;

  assign wr_w      = bus.wr_en_in[winner_q];
  assign req_w     = bus.req_in[winner_q];
  assign addr_w    = bus.addr_in[winner_q*ADDR_W +: ADDR_W];
  assign element_w = bus.element_in[winner_q*32 +: 32];
  assign i_w       = bus.i_loc_in[winner_q*MW +: MW];
  assign j_w       = bus.j_loc_in[winner_q*NW +: NW];
  assign m_w       = bus.m_size_in[winner_q*MW +: MW];
  assign n_w       = bus.n_size_in[winner_q*NW +: NW];
  assign grant_act = |grant_q;

  // Zero sizes are rejected upstream; guard so they can never look like the last element
  assign last_c = wr_w && (m_w != '0) && (n_w != '0) &&
                  (i_w == MW'(m_w - MW'(1))) && (j_w == NW'(n_w - NW'(1)));

  assign ptr_next = (winner_q == PW'(NREQ - 1)) ? '0 : PW'(winner_q + PW'(1));

  // Round-robin pick: first set request at or above rr_ptr, wrapping.
  // Scanned from the far end so the nearest candidate is assigned last.
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % int'(NREQ);
      if (bus.req_in[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  // Arbitration FSM with registered grant and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      winner_q  <= '0;
      grant_q   <= '0;
      abort_q   <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      abort_q   <= 1'b0;
      collide_q <= |(bus.wr_en_in & ~grant_q);
      case (state_q)
        ARB_IDLE: begin
          if (bus.reg_ready_in && pick_valid) begin
            winner_q <= pick_idx;
            grant_q  <= NREQ'(1) << pick_idx;
            state_q  <= ARB_GRANT;
          end
        end
        ARB_GRANT, ARB_XFER: begin
          // Completion wins over a request drop in the same cycle
          if (last_c) begin
            grant_q  <= '0;
            rr_ptr_q <= ptr_next;
            state_q  <= ARB_IDLE;
          end else if (!req_w) begin
            abort_q  <= 1'b1;
            grant_q  <= '0;
            rr_ptr_q <= ptr_next;
            state_q  <= ARB_IDLE;
          end else if ((state_q == ARB_GRANT) && wr_w) begin
            state_q  <= ARB_XFER;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Data path is combinational from the granted requester; zero with no grant
  assign bus.grant_out       = grant_q;
  assign bus.reg_en_out      = grant_act & wr_w;
  assign bus.reg_addr_out    = grant_act ? addr_w    : '0;
  assign bus.reg_element_out = grant_act ? element_w : '0;
  assign bus.reg_i_loc_out   = grant_act ? i_w       : '0;
  assign bus.reg_j_loc_out   = grant_act ? j_w       : '0;
  assign bus.reg_m_size_out  = grant_act ? m_w       : '0;
  assign bus.reg_n_size_out  = grant_act ? n_w       : '0;
  assign bus.busy_out        = (state_q != ARB_IDLE);
  assign bus.abort_out       = abort_q;
  assign bus.collide_out     = collide_q;

endmodule

// File: tb/tb_mpu_reg_write_arbiter.sv
// Directed bench for mpu_reg_write_arbiter with a write scoreboard.
module tb_mpu_reg_write_arbiter;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned MW     = 3;
  localparam int unsigned NW     = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       element;
    logic [MW-1:0]     i;
    logic [NW-1:0]     j;
    logic [MW-1:0]     m;
    logic [NW-1:0]     n;
  } wr_rec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  wr_rec_t exp_q[$];

  mpu_reg_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .MW(MW), .NW(NW)) bus ();

  mpu_reg_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .MW(MW), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_en_in = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Drive one element for requester r for one cycle; push expectation if it should be written
  task automatic elem(input int r, input int i, input int j, input int m, input int n,
                      input bit expect_wr);
    wr_rec_t rec;
    rec.addr    = ADDR_W'(r + 5);
    rec.element = $urandom;
    rec.i       = MW'(i);
    rec.j       = NW'(j);
    rec.m       = MW'(m);
    rec.n       = NW'(n);
    bus.addr_in[r*ADDR_W +: ADDR_W] = rec.addr;
    bus.element_in[r*32 +: 32]      = rec.element;
    bus.i_loc_in[r*MW +: MW]        = rec.i;
    bus.j_loc_in[r*NW +: NW]        = rec.j;
    bus.m_size_in[r*MW +: MW]       = rec.m;
    bus.n_size_in[r*NW +: NW]       = rec.n;
    bus.wr_en_in = NREQ'(1) << r;
    if (expect_wr) exp_q.push_back(rec);
    step();
    bus.wr_en_in = '0;
  endtask

  task automatic matrix(input int r, input int m, input int n);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        elem(r, i, j, m, n, 1'b1);
  endtask

  // Scoreboard: every register-file write must match the next expected element
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_en_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bus.reg_element_out), 64'hDEAD);
        end else begin
          wr_rec_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.reg_addr_out), 64'(e.addr));
          check("wr_elem", 64'(bus.reg_element_out), 64'(e.element));
          check("wr_ij", 64'({bus.reg_i_loc_out, bus.reg_j_loc_out}), 64'({e.i, e.j}));
          check("wr_mn", 64'({bus.reg_m_size_out, bus.reg_n_size_out}), 64'({e.m, e.n}));
        end
      end
      if (bus.grant_out == '0)
        check("nogrant_elem_zero", 64'(bus.reg_element_out), 64'h0);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_in       = '0;
    bus.wr_en_in     = '0;
    bus.addr_in      = '0;
    bus.element_in   = '0;
    bus.i_loc_in     = '0;
    bus.j_loc_in     = '0;
    bus.m_size_in    = '0;
    bus.n_size_in    = '0;
    bus.reg_ready_in = 1'b0;
    do_reset();

    // reset state
    check("rst_grant", 64'(bus.grant_out), 64'h0);
    check("rst_busy", 64'(bus.busy_out), 64'h0);
    check("rst_abort", 64'(bus.abort_out), 64'h0);
    check("rst_collide", 64'(bus.collide_out), 64'h0);
    check("rst_reg_en", 64'(bus.reg_en_out), 64'h0);

    // 1: single requester, 2x2 transfer
    bus.req_in = 2'b01;
    bus.reg_ready_in = 1'b1;
    step();
    check("t1_grant", 64'(bus.grant_out), 64'h1);
    check("t1_busy", 64'(bus.busy_out), 64'h1);
    matrix(0, 2, 2);
    bus.req_in = 2'b00;
    check("t1_grant_done", 64'(bus.grant_out), 64'h0);
    check("t1_idle", 64'(bus.busy_out), 64'h0);

    // 2: both requesting from reset, round-robin alternation
    do_reset();
    bus.req_in = 2'b11;
    step();
    check("t2_first_grant", 64'(bus.grant_out), 64'h1);
    matrix(0, 2, 2);
    check("t2_idle_gap", 64'(bus.grant_out), 64'h0);
    step();
    check("t2_second_grant", 64'(bus.grant_out), 64'h2);
    matrix(1, 1, 2);
    check("t2_idle_gap2", 64'(bus.grant_out), 64'h0);
    step();
    check("t2_third_grant", 64'(bus.grant_out), 64'h1);

    // 3: req1 waiting during a 3x3 req0 transfer; ready drop mid-transfer ignored
    bus.reg_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        elem(0, i, j, 3, 3, 1'b1);
        if (!(i == 2 && j == 2)) check("t3_grant_locked", 64'(bus.grant_out), 64'h1);
      end
    end
    check("t3_grant_released", 64'(bus.grant_out), 64'h0);
    bus.reg_ready_in = 1'b1;
    step();
    check("t3_req1_grant", 64'(bus.grant_out), 64'h2);

    // 4: req0 dropped after 2 of 4 elements
    do_reset();
    bus.req_in = 2'b01;
    step();
    check("t4_grant", 64'(bus.grant_out), 64'h1);
    elem(0, 0, 0, 2, 2, 1'b1);
    elem(0, 0, 1, 2, 2, 1'b1);
    bus.req_in = 2'b00;
    step();
    check("t4_abort", 64'(bus.abort_out), 64'h1);
    check("t4_grant_clear", 64'(bus.grant_out), 64'h0);
    check("t4_idle", 64'(bus.busy_out), 64'h0);
    step();
    check("t4_abort_pulse", 64'(bus.abort_out), 64'h0);
    bus.req_in = 2'b11;
    step();
    check("t4_rr_advanced", 64'(bus.grant_out), 64'h2);

    // 5: wr_en from non-granted requester
    do_reset();
    bus.req_in = 2'b01;
    step();
    check("t5_grant", 64'(bus.grant_out), 64'h1);
    bus.element_in[32 +: 32] = 32'h1234_5678;
    bus.wr_en_in = 2'b10;
    #1;
    check("t5_reg_en_blocked", 64'(bus.reg_en_out), 64'h0);
    step();
    bus.wr_en_in = 2'b00;
    check("t5_collide", 64'(bus.collide_out), 64'h1);
    step();
    check("t5_collide_pulse", 64'(bus.collide_out), 64'h0);
    matrix(0, 2, 2);
    bus.req_in = 2'b11;
    step();
    check("t5_req1_grant", 64'(bus.grant_out), 64'h2);

    // 6: reset mid-transfer, then reg_ready gating
    elem(1, 0, 0, 2, 2, 1'b1);
    rst = 1'b1;
    step();
    check("t6_rst_grant", 64'(bus.grant_out), 64'h0);
    check("t6_rst_busy", 64'(bus.busy_out), 64'h0);
    rst = 1'b0;
    bus.reg_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      elem(0, 0, 0, 2, 2, 1'b0);
      check("t6_no_grant_unready", 64'(bus.grant_out), 64'h0);
    end
    bus.reg_ready_in = 1'b1;
    step();
    check("t6_grant_rr_reset", 64'(bus.grant_out), 64'h1);
    bus.req_in = 2'b00;
    step();
    step();

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
